// File: rtl/test_monitor.sv
// Simulation-side test monitor: UART 8N1 receiver feeding a show-ahead FIFO,
// plus a PASS/FAIL/TIMEOUT status machine driven by SoC completion flags.
`timescale 1ns/1ps
module test_monitor #(
    parameter int                  CLKS_PER_BIT   = 16,
    parameter int                  FIFO_DEPTH     = 16,
    parameter int                  NUM_DONE       = 4,
    parameter logic [NUM_DONE-1:0] DONE_MASK      = NUM_DONE'(1),
    parameter int                  TIMEOUT_CYCLES = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                uart_rx,
    input  logic [NUM_DONE-1:0] done_in,
    input  logic                fail_in,
    input  logic                rd_en,
    output logic [7:0]          rx_data,
    output logic                rx_valid,
    output logic                overflow,
    output logic                frame_err,
    output logic [15:0]         char_count,
    output logic [1:0]          status,
    output logic                finished
);

    localparam int              AW       = $clog2(FIFO_DEPTH);
    localparam int              CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]   HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0]   FULL_M1  = CW'(CLKS_PER_BIT - 1);
    localparam bit              TMO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [31:0]     TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
    typedef enum logic [1:0] {ST_RUNNING = 2'd0, ST_PASS = 2'd1,
                              ST_FAIL = 2'd2, ST_TIMEOUT = 2'd3} status_e;

    logic                rx_meta_q, rx_sync_q;
    logic [NUM_DONE-1:0] done_meta_q, done_sync_q;
    logic                fail_meta_q, fail_sync_q;

    rx_state_e           rx_state_q, rx_state_d;
    logic [CW-1:0]       tick_q, tick_d;
    logic [2:0]          bit_idx_q, bit_idx_d;
    logic [7:0]          shift_q, shift_d;
    logic                push, stop_bad;

    logic [7:0]          mem_q [FIFO_DEPTH];
    logic [AW:0]         wr_ptr_q, rd_ptr_q;
    logic                fifo_full, fifo_empty, do_rd, do_wr;
    logic                overflow_q, frame_err_q;
    logic [15:0]         char_count_q;

    status_e             status_q, status_d;
    logic [31:0]         tmo_cnt_q, tmo_cnt_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta_q   <= 1'b1;
            rx_sync_q   <= 1'b1;
            done_meta_q <= '0;
            done_sync_q <= '0;
            fail_meta_q <= 1'b0;
            fail_sync_q <= 1'b0;
        end else begin
            rx_meta_q   <= uart_rx;
            rx_sync_q   <= rx_meta_q;
            done_meta_q <= done_in;
            done_sync_q <= done_meta_q;
            fail_meta_q <= fail_in;
            fail_sync_q <= fail_meta_q;
        end
    end

    // Receiver: START waits half a bit so every later sample lands mid-bit.
    always_comb begin
        rx_state_d = rx_state_q;
        tick_d     = tick_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        push       = 1'b0;
        stop_bad   = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (!rx_sync_q) begin
                    rx_state_d = RX_START;
                    tick_d     = '0;
                    bit_idx_d  = '0;
                end
            end
            RX_START: begin
                if (tick_q == HALF_M1) begin
                    tick_d     = '0;
                    bit_idx_d  = '0;
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (tick_q == FULL_M1) begin
                    tick_d    = '0;
                    shift_d   = {rx_sync_q, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (tick_q == FULL_M1) begin
                    tick_d     = '0;
                    push       = rx_sync_q;
                    stop_bad   = !rx_sync_q;
                    rx_state_d = RX_IDLE;
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_state_q <= RX_IDLE;
            tick_q     <= '0;
            bit_idx_q  <= '0;
        end else begin
            rx_state_q <= rx_state_d;
            tick_q     <= tick_d;
            bit_idx_q  <= bit_idx_d;
        end
    end

    always_ff @(posedge clk) begin
        shift_q <= shift_d;
    end

    // Pointer MSB differs only when the FIFO has wrapped once: full vs empty.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_rd      = rd_en && !fifo_empty;
    assign do_wr      = push && (!fifo_full || do_rd);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            overflow_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            char_count_q <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr_q     <= wr_ptr_q + 1'b1;
                char_count_q <= char_count_q + 16'd1;
            end
            if (do_rd) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push && fifo_full && !do_rd) begin
                overflow_q <= 1'b1;
            end
            if (stop_bad) begin
                frame_err_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q[AW-1:0]] <= shift_q;
        end
    end

    assign rx_data    = fifo_empty ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];
    assign rx_valid   = !fifo_empty;
    assign overflow   = overflow_q;
    assign frame_err  = frame_err_q;
    assign char_count = char_count_q;

    // Status decisions are made only while RUNNING; all outcomes are terminal.
    always_comb begin
        status_d  = status_q;
        tmo_cnt_d = tmo_cnt_q;
        if (status_q == ST_RUNNING) begin
            if (tmo_cnt_q != 32'hFFFF_FFFF) begin
                tmo_cnt_d = tmo_cnt_q + 32'd1;
            end
            if (fail_sync_q) begin
                status_d = ST_FAIL;
            end else if ((done_sync_q & DONE_MASK) == DONE_MASK) begin
                status_d = ST_PASS;
            end else if (TMO_EN && (tmo_cnt_q == TMO_LAST)) begin
                status_d = ST_TIMEOUT;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            status_q  <= ST_RUNNING;
            tmo_cnt_q <= '0;
        end else begin
            status_q  <= status_d;
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    assign status   = status_q;
    assign finished = (status_q != ST_RUNNING);

endmodule

// File: doc/test_monitor.md
TEST_MONITOR -- requirements
Module: test_monitor

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16: clk cycles per UART bit, minimum 4.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16: receive FIFO entries, a power of two, minimum 2.
REQ-003 SHALL have parameter NUM_DONE, default 4: width of done_in.
REQ-004 SHALL have parameter DONE_MASK, default 1: the done_in bits that must all be high for PASS.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 0: cycles to TIMEOUT; 0 disables the timeout.
REQ-006 SHALL have one clock and asynchronous active-high reset: clk (input, 1) and reset (input, 1, async, active-high).
REQ-007 SHALL have port uart_rx (input, 1): serial line from the DUT, idle high, 8N1, LSB first.
REQ-008 SHALL have port done_in (input, NUM_DONE): completion flags, e.g. SoC leds.
REQ-009 SHALL have port fail_in (input, 1): failure flag.
REQ-010 SHALL have port rd_en (input, 1): pops the FIFO head.
REQ-011 SHALL have port rx_data (output, 8): FIFO head, show-ahead.
REQ-012 SHALL have port rx_valid (output, 1): FIFO not empty.
REQ-013 SHALL have port overflow (output, 1): sticky flag, set when a character is dropped on a full FIFO.
REQ-014 SHALL have port frame_err (output, 1): sticky flag, set on a bad stop bit.
REQ-015 SHALL have port char_count (output, 16): characters accepted into the FIFO, wrapping.
REQ-016 SHALL have port status (output, 2): 0 RUNNING, 1 PASS, 2 FAIL, 3 TIMEOUT.
REQ-017 SHALL have port finished (output, 1): high when status is not RUNNING.

Function
REQ-018 SHALL pass uart_rx, done_in and fail_in through a 2-flop synchronizer, reset value 1 for uart_rx and 0 for the others; all logic below uses the synchronized values.
REQ-019 SHALL implement the receiver FSM states IDLE, START, DATA, STOP.
REQ-020 IDLE: a synchronized rx of 0 SHALL move the FSM to START and clear the bit counter.
REQ-021 START: at count CLKS_PER_BIT/2-1, rx=0 SHALL move to DATA and rx=1 SHALL return to IDLE (glitch), with no flag set.
REQ-022 DATA: SHALL sample rx every CLKS_PER_BIT cycles from the start mid-point, shifting LSB first; after the 8th sample it SHALL move to STOP.
REQ-023 STOP: after CLKS_PER_BIT cycles, rx=1 SHALL push the byte and rx=0 SHALL discard it and set frame_err; either way the FSM returns to IDLE the next cycle.
REQ-024 A new start bit SHALL be detected no earlier than the first IDLE cycle after STOP.
REQ-025 On a push with the FIFO not full, the byte SHALL become visible on rx_data/rx_valid the cycle after the STOP sample, and char_count SHALL increment (0xFFFF wraps to 0).
REQ-026 On a push with the FIFO full and rd_en low, the byte SHALL be dropped, overflow set and char_count unchanged.
REQ-027 Push and rd_en in the same cycle with the FIFO full SHALL both take effect, with occupancy unchanged and no overflow.
REQ-028 rd_en with the FIFO empty SHALL be ignored; in the same cycle a push still succeeds.
REQ-029 rd_en with the FIFO non-empty SHALL advance the head on the next edge.
REQ-030 Read and write pointers SHALL be log2(FIFO_DEPTH)+1 bits wide, wrap modulo 2*FIFO_DEPTH, and distinguish full from empty by the MSB.
REQ-031 The timeout counter SHALL be 32 bits, increment each cycle while RUNNING, and saturate.
REQ-032 The status FSM SHALL evaluate in RUNNING only; among simultaneous conditions the priority SHALL be: fail_in → FAIL; else (done_in & DONE_MASK)==DONE_MASK → PASS; else TIMEOUT_CYCLES≠0 and counter == TIMEOUT_CYCLES-1 → TIMEOUT.
REQ-033 The status transition SHALL register on the evaluating edge.
REQ-034 PASS, FAIL and TIMEOUT SHALL be terminal until reset; later done_in/fail_in changes SHALL be ignored.
REQ-035 The receiver and FIFO SHALL keep operating after finished, so trailing characters drain.

Reset
REQ-036 Asserting reset SHALL immediately drive rx_valid=0, rx_data=0, overflow=0, frame_err=0, char_count=0, status=0, finished=0.
REQ-037 Asserting reset SHALL clear both FIFO pointers, the timeout counter and both FSMs (to IDLE and RUNNING).
REQ-038 Reset asserted mid-character SHALL abort the character, push nothing, and leave no flag set after release.
REQ-039 After reset release, reception SHALL resume at the next falling edge of the synchronized rx.

Verification
REQ-040 CLKS_PER_BIT=4: send 0x41, then 0x0A -> rx_data 0x41 with rx_valid=1; after one rd_en, 0x0A; char_count=2; frame_err=0.
REQ-041 uart_rx low 1 cycle in IDLE -> no push, frame_err=0, FSM back in IDLE.
REQ-042 Send 0x55 with the stop bit held low -> frame_err=1, rx_valid=0, char_count=0.
REQ-043 FIFO_DEPTH=4: send 5 bytes without rd_en -> the first 4 held, overflow=1, char_count=4; repeat with rd_en pulsed during the 5th push -> overflow=0, char_count=5.
REQ-044 DONE_MASK=4'b0011: raise done_in=4'b0001 -> status=0; then 4'b0011 -> status=1, finished=1; later fail_in=1 -> status stays 1.
REQ-045 TIMEOUT_CYCLES=100, no done -> status=3 exactly 100 cycles after release; with fail_in and the done mask raised together -> status=2.
